// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from gate primitives; the only arithmetic in the
// serial adder, reused once per bit over successive cycles.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   logic ab_x;
   logic ab_a;
   logic cx_a;

   xor g_ab_x  (ab_x, a, b);
   xor g_sum   (sum, ab_x, c_in);
   and g_ab_a  (ab_a, a, b);
   and g_cx_a  (cx_a, ab_x, c_in);
   or  g_c_out (c_out, ab_a, cx_a);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {c_out,sum} = a + b + c_in, one bit per cycle, LSB first.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last answer
// RUN   | WIDTH cycles, one full-adder step per cycle
// DONE  | one cycle, done pulses, sum/c_out final
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state_q;
   state_t           state_d;
   logic             load;
   logic             step;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sum_q;
   logic             c_out_q;
   logic             fa_s;
   logic             fa_c;
   logic             last_bit;

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   fa_cell u_fa (
      .a     (a_q[0]),
      .b     (b_q[0]),
      .c_in  (carry_q),
      .sum   (fa_s),
      .c_out (fa_c)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode plus load/step strobes; busy/done come straight from
   // the state so reset clears them without waiting for a clock.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (last_bit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand shifters, carry flop, bit counter and result registers.
   // The counter parks on WIDTH-1 instead of wrapping on the final step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
      end else if (load) begin
         a_q     <= a;
         b_q     <= b;
         carry_q <= c_in;
         cnt_q   <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
      end else if (step) begin
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         carry_q <= fa_c;
         sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
         if (last_bit) begin
            c_out_q <= fa_c;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign sum   = sum_q;
   assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;

   localparam int W = 8;
   localparam int LAT = W;          // samples after the accepting edge until done
   localparam int PERIOD = W + 2;   // result spacing with start held high

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;

   int errors = 0;
   int checks = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer addition, result is WIDTH+1 bits wide.
   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
   endfunction

   // Launches one addition from an IDLE sample point and waits for done.
   // Operands are scrambled right after acceptance. Returns done_at = -1 on
   // timeout; leaves the bench at the sample point where done was seen.
   task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         output int done_at, output logic [W-1:0] s, output logic co);
      start = 1'b1; a = av; b = bv; c_in = cv;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      done_at = -1; s = '0; co = 1'b0;
      for (int k = 0; k < LAT + 6; k++) begin
         if (done === 1'b1) begin
            done_at = k; s = sum; co = c_out;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic check_result(input string name, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic cv);
      int da; logic [W-1:0] s; logic co; logic [W:0] exp;
      exp = ref_add(av, bv, cv);
      launch(av, bv, cv, da, s, co);
      checks++;
      if (da !== LAT) begin
         errors++; $display("FAIL %s done_latency got=%0d exp=%0d", name, da, LAT);
      end
      checks++;
      if (s !== exp[W-1:0]) begin
         errors++; $display("FAIL %s sum got=%h exp=%h", name, s, exp[W-1:0]);
      end
      checks++;
      if (co !== exp[W]) begin
         errors++; $display("FAIL %s c_out got=%b exp=%b", name, co, exp[W]);
      end
      @(posedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++; $display("FAIL %s idle_after got busy/done=%b exp=00", name, {busy, done});
      end
      checks++;
      if ({c_out, sum} !== exp) begin
         errors++; $display("FAIL %s hold got=%h exp=%h", name, {c_out, sum}, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
      #2;
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++; $display("FAIL reset busy/done got=%b exp=00", {busy, done});
      end
      checks++;
      if ({c_out, sum} !== '0) begin
         errors++; $display("FAIL reset result got=%h exp=0", {c_out, sum});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      // First launch right after reset release checks first-edge acceptance.
      check_result("d_5a_3c", 8'h5A, 8'h3C, 1'b0);
      check_result("d_ff_01", 8'hFF, 8'h01, 1'b0);
      check_result("d_ff_ff_c", 8'hFF, 8'hFF, 1'b1);
      check_result("d_00_00_c", 8'h00, 8'h00, 1'b1);
      check_result("d_80_80", 8'h80, 8'h80, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
         end
         check_result("random", W'($urandom), W'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_ignore_start();
      int da; int n_done; logic [W-1:0] s; logic co; logic [W:0] exp;
      exp = ref_add(8'h5A, 8'h3C, 1'b0);
      start = 1'b1; a = 8'h5A; b = 8'h3C; c_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      da = -1; n_done = 0; s = '0; co = 1'b0;
      for (int k = 0; k < LAT + 6; k++) begin
         start = (k == 2);
         if (k == 2) begin a = 8'h11; b = 8'h22; c_in = 1'b1; end
         if (done === 1'b1) begin
            n_done++;
            if (da < 0) begin da = k; s = sum; co = c_out; end
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      checks++;
      if (n_done !== 1) begin
         errors++; $display("FAIL ignore done_count got=%0d exp=1", n_done);
      end
      checks++;
      if (da !== LAT) begin
         errors++; $display("FAIL ignore done_latency got=%0d exp=%0d", da, LAT);
      end
      checks++;
      if ({co, s} !== exp) begin
         errors++; $display("FAIL ignore result got=%h exp=%h", {co, s}, exp);
      end
   endtask

   task automatic test_reset_abort();
      int n_done;
      start = 1'b1; a = 8'hFF; b = 8'h00; c_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, c_out, sum} !== '0) begin
         errors++;
         $display("FAIL abort async_clear got busy=%b done=%b c_out=%b sum=%h exp=all0",
                  busy, done, c_out, sum);
      end
      n_done = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) n_done++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < LAT + 3; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) n_done++;
      end
      checks++;
      if (n_done !== 0) begin
         errors++; $display("FAIL abort spurious_done got=%0d exp=0", n_done);
      end
      check_result("after_abort", 8'hA7, 8'h6B, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [W:0] exp; logic exp_done; int bad_done; int bad_sum; int overlap;
      exp = ref_add(8'h77, 8'h99, 1'b1);
      bad_done = 0; bad_sum = 0; overlap = 0;
      start = 1'b1; a = 8'h77; b = 8'h99; c_in = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         exp_done = ((i % PERIOD) == LAT);
         if (done !== exp_done) begin
            bad_done++;
            $display("FAIL b2b done@%0d got=%b exp=%b", i, done, exp_done);
         end
         if (done === 1'b1 && {c_out, sum} !== exp) begin
            bad_sum++;
            $display("FAIL b2b result@%0d got=%h exp=%h", i, {c_out, sum}, exp);
         end
         if (done === 1'b1 && busy !== 1'b1) begin
            overlap++;
            $display("FAIL b2b done_without_busy@%0d got busy=%b exp=1", i, busy);
         end
      end
      start = 1'b0;
      checks += 3;
      errors += (bad_done != 0) + (bad_sum != 0) + (overlap != 0);
      for (int k = 0; k < PERIOD + 2; k++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL b2b drain busy got=%b exp=0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_abort();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
